// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Frame = start(0), 8 data bits MSB first, stop(1), no parity.
// Each line bit lasts CLKS_PER_BIT clocks. A byte is popped into the
// shift register one cycle after it lands in an empty FIFO; consecutive
// frames run back to back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1992,
  parameter int FIFO_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  UART_TX,
  output logic                  busy,
  output logic [FIFO_WIDTH:0]   fifo_count
);

  localparam int DEPTH  = 1 << FIFO_WIDTH;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_WIDTH:0] FULL_COUNT = (FIFO_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]            mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] rd_ptr;
  logic [FIFO_WIDTH:0]   count_q;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;

  // Transmitter state
  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                baud_done;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign baud_done  = (baud_q == BAUD_LAST);

  // Write the incoming byte into the slot addressed by the write pointer.
  // NOTE: the storage array is deliberately left out of reset; the count and
  // pointers decide what is valid, and a resettable RAM would cost flops.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy update; push and pop together leave the count alone.
  // NOTE: every sequential assignment is non-blocking so all flops sample the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmitter registers; reset truncates any frame and idles the line high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state and next-line-value logic for the frame sequencer.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (baud_done) begin
          tx_d      = shift_q[7];
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            tx_d      = shift_q[6];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign UART_TX    = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo.
// DUT "a" runs with a short bit time and a 4-entry FIFO against a
// frame-timing reference model and an independent line decoder; DUT "b"
// runs with the default parameters for exact bit-timing measurement.
module tb_uart_tx_fifo;

  localparam int C_A     = 4;
  localparam int W_A     = 2;
  localparam int DEPTH_A = 1 << W_A;
  localparam int C_B     = 1992;
  localparam int W_B     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a signals
  logic         rst_a;
  logic [7:0]   in_data_a;
  logic         in_valid_a;
  logic         ready_a;
  logic         tx_a;
  logic         busy_a;
  logic [W_A:0] fifo_count_a;

  // DUT b signals
  logic         rst_b;
  logic [7:0]   in_data_b;
  logic         in_valid_b;
  logic         ready_b;
  logic         tx_b;
  logic         busy_b;
  logic [W_B:0] fifo_count_b;

  uart_tx_fifo #(.CLKS_PER_BIT(C_A), .FIFO_WIDTH(W_A)) dut_a (
    .CLK        (clk),
    .RST        (rst_a),
    .in_data    (in_data_a),
    .in_valid   (in_valid_a),
    .in_ready   (ready_a),
    .UART_TX    (tx_a),
    .busy       (busy_a),
    .fifo_count (fifo_count_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(C_B), .FIFO_WIDTH(W_B)) dut_b (
    .CLK        (clk),
    .RST        (rst_b),
    .in_data    (in_data_b),
    .in_valid   (in_valid_b),
    .in_ready   (ready_b),
    .UART_TX    (tx_b),
    .busy       (busy_b),
    .fifo_count (fifo_count_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line value of bit position b (0=start .. 9=stop) of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[8 - b];
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Reference model for DUT a: a queue of waiting bytes plus the elapsed
  // clock count of the frame currently on the line.
  // ---------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_active = 1'b0;
  int         m_elapsed = 0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    int  pre;
    bit  do_push;
    if (rst_a) begin
      m_q.delete();
      m_active  = 1'b0;
      m_elapsed = 0;
    end else begin
      pre     = m_q.size();
      do_push = in_valid_a && (pre < DEPTH_A);
      if (!m_active) begin
        if (pre > 0) begin
          m_cur     = m_q.pop_front();
          m_active  = 1'b1;
          m_elapsed = 0;
        end
      end else begin
        m_elapsed++;
        if (m_elapsed == 10 * C_A) begin
          exp_q.push_back(m_cur);
          if (pre > 0) begin
            m_cur     = m_q.pop_front();
            m_elapsed = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end
      if (do_push) m_q.push_back(in_data_a);
    end
  end

  function automatic logic model_tx();
    if (!m_active) return 1'b1;
    return frame_bit(m_cur, m_elapsed / C_A);
  endfunction

  // Cycle-by-cycle comparison of DUT a against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx",    32'(tx_a),         32'(model_tx()));
      check("count", 32'(fifo_count_a), 32'(m_q.size()));
      check("ready", 32'(ready_a),      32'(m_q.size() < DEPTH_A));
      check("busy",  32'(busy_a),       32'(m_active || (m_q.size() != 0)));
    end
  end

  // Independent line decoder for DUT a: mid-bit sampling from the start edge.
  logic [7:0] rx_q[$];
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (rst_a) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx_a === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % C_A) == (C_A / 2)) begin
        rx_bit = rx_cnt / C_A;
        if (rx_bit == 0) begin
          check("rx_start", 32'(tx_a), 32'd0);
        end else if (rx_bit <= 8) begin
          rx_byte[8 - rx_bit] = tx_a;
        end else begin
          check("rx_stop", 32'(tx_a), 32'd1);
          rx_q.push_back(rx_byte);
          rx_on = 1'b0;
        end
      end
    end
  end

  // Inputs change just after the falling edge so every sampler sees them stable.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    in_valid_a = 1'b1;
    in_data_a  = d;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (busy_a !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout_a", 32'(n < budget), 32'd1);
    repeat (3) tick();
  endtask

  // Wait until the model is on cycle `el` of a frame with `qs` bytes waiting.
  task automatic wait_frame_pos(input string tag, input int el, input int qs);
    int n = 0;
    while (!(m_active && m_elapsed == el && m_q.size() == qs) && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin
    logic [7:0] rxb;
    int         bb;

    rst_a = 1'b1; rst_b = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00;
    in_valid_b = 1'b0; in_data_b = 8'h00;
    tick();
    tick();

    // Reset state
    check("rst_tx_a",    32'(tx_a),         32'd1);
    check("rst_ready_a", 32'(ready_a),      32'd1);
    check("rst_busy_a",  32'(busy_a),       32'd0);
    check("rst_count_a", 32'(fifo_count_a), 32'd0);
    check("rst_tx_b",    32'(tx_b),         32'd1);
    check("rst_busy_b",  32'(busy_b),       32'd0);
    chk_en = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) tick();

    // Single byte: start 1 cycle after push, busy falls 41 cycles after push.
    push_a(8'hA5);
    check("a5_count", 32'(fifo_count_a), 32'd1);
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 1)  check("a5_start", 32'(tx_a), 32'd0);
      if (k == 40) check("a5_busy40", 32'(busy_a), 32'd1);
      if (k == 41) check("a5_busy41", 32'(busy_a), 32'd0);
    end
    repeat (3) tick();

    // Back-to-back 0x00 then 0xFF; second start directly after first stop.
    in_valid_a = 1'b1; in_data_a = 8'h00; tick();
    in_data_a = 8'hFF; tick();
    in_valid_a = 1'b0;
    for (int k = 2; k <= 41; k++) begin
      tick();
      if (k == 40) check("b2b_stop", 32'(tx_a), 32'd1);
      if (k == 41) check("b2b_start2", 32'(tx_a), 32'd0);
    end
    wait_idle_a(200);

    // Full FIFO: offer 0x01..0x06 on consecutive cycles.
    for (int i = 1; i <= 6; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 8'(i);
      tick();
      if (i == 5) check("full_ready", 32'(ready_a), 32'd0);
      if (i == 5) check("full_count", 32'(fifo_count_a), 32'(DEPTH_A));
    end
    in_valid_a = 1'b0;
    wait_idle_a(400);

    // Push on the same edge the end of STOP pops the next byte.
    push_a(8'h11);
    push_a(8'h22);
    wait_frame_pos("pp_wait", 10 * C_A - 1, 1);
    in_valid_a = 1'b1; in_data_a = 8'h33;
    tick();
    in_valid_a = 1'b0;
    check("pp_count", 32'(fifo_count_a), 32'd1);
    check("pp_start", 32'(tx_a), 32'd0);
    wait_idle_a(300);

    // Reset during data bit 3 of 0x3C with bytes queued.
    push_a(8'h3C);
    push_a(8'h44);
    push_a(8'h45);
    wait_frame_pos("rst_wait", 4 * C_A + 1, 2);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("mid_rst_tx",    32'(tx_a),         32'd1);
    check("mid_rst_busy",  32'(busy_a),       32'd0);
    check("mid_rst_count", 32'(fifo_count_a), 32'd0);
    repeat (2) tick();
    push_a(8'hC3);
    wait_idle_a(200);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      in_valid_a = ($urandom_range(0, 3) == 0);
      in_data_a  = 8'($urandom);
      tick();
    end
    in_valid_a = 1'b0;
    wait_idle_a(400);

    // Decoded line bytes must equal the completed frames, in order.
    check("rx_len", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk_en = 1'b0;

    // Default timing: every bit exactly C_B cycles, frame 10*C_B.
    in_valid_b = 1'b1; in_data_b = 8'h55;
    tick();
    in_valid_b = 1'b0;
    check("b_count0", 32'(fifo_count_b), 32'd1);
    rxb = 8'h00;
    for (int k = 1; k <= 10 * C_B + 1; k++) begin
      tick();
      if (k == 1) check("b_count1", 32'(fifo_count_b), 32'd0);
      if (k <= 10 * C_B) begin
        if ((k - 1) % C_B == 0) begin
          bb = (k - 1) / C_B;
          check($sformatf("b_first%0d", bb), 32'(tx_b), 32'(frame_bit(8'h55, bb)));
        end
        if (k % C_B == 0) begin
          bb = k / C_B - 1;
          check($sformatf("b_last%0d", bb), 32'(tx_b), 32'(frame_bit(8'h55, bb)));
        end
        if ((k - 1) % C_B == C_B / 2) begin
          bb = (k - 1) / C_B;
          if (bb >= 1 && bb <= 8) rxb[8 - bb] = tx_b;
        end
      end
      if (k == 10 * C_B)     check("b_busy_end", 32'(busy_b), 32'd1);
      if (k == 10 * C_B + 1) begin
        check("b_busy_off", 32'(busy_b), 32'd0);
        check("b_idle_tx",  32'(tx_b),   32'd1);
      end
    end
    check("b_rx", 32'(rxb), 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
